dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_store_buffer.sv | 73 +++++++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared parameters and types for the data-memory responder
//
// Purpose: default widths/depths used by the interface, the top and the store buffer,
//          plus the per-cycle SRAM port grant encoding.
// Ports:   none (package).
package dmem_responder_pkg;

    localparam int W_OPR_DEF    = 32;   // data word width
    localparam int ADDR_DEF     = 16;   // word address width
    localparam int MEM_LOG2_DEF = 10;   // log2 of SRAM depth in words
    localparam int SB_DEPTH_DEF = 4;    // store-buffer entries, power of two, >= 2

    // Owner of the single SRAM port for one cycle.
    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DRAIN_FULL,
        GNT_LOAD,
        GNT_DRAIN
    } port_grant_e;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store bus between execute stage and data-memory responder
//
// Purpose: bundles the execute-stage load/store request signals and the responder results.
// Ports:   master = execute stage (drives requests, hold), slave = dmem_responder.
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int W_OPR = W_OPR_DEF,
    parameter int ADDR  = ADDR_DEF
) ();

    logic [ADDR-1:0]  ldst_addr_i;
    logic             ldst_write_i;
    logic             ldst_read_i;
    logic [W_OPR-1:0] ldst_data_i;
    logic             hold_i;
    logic [W_OPR-1:0] ldst_data_o;
    logic             rd_valid_o;
    logic             full_o;
    logic             err_o;

    modport master (
        output ldst_addr_i, ldst_write_i, ldst_read_i, ldst_data_i, hold_i,
        input  ldst_data_o, rd_valid_o, full_o, err_o
    );

    modport slave (
        input  ldst_addr_i, ldst_write_i, ldst_read_i, ldst_data_i, hold_i,
        output ldst_data_o, rd_valid_o, full_o, err_o
    );

endinterface

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - in-order {addr, data} store FIFO with youngest-match lookup
//
// Purpose: holds stores until the SRAM port is free; answers load forwarding queries.
// Ports:   clk, reset (sync, active-high); push/push_addr/push_data enqueue;
//          pop dequeues the head; head_idx/head_data = oldest entry (SRAM index, data);
//          count = occupancy 0..DEPTH; lookup_addr -> hit/hit_data (youngest matching entry).
module dmem_store_buffer #(
    parameter int W_OPR = 32,
    parameter int ADDR  = 16,
    parameter int DEPTH = 4,
    parameter int IDX_W = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ADDR-1:0]              push_addr,
    input  logic [W_OPR-1:0]             push_data,
    input  logic                         pop,
    output logic [IDX_W-1:0]             head_idx,
    output logic [W_OPR-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [ADDR-1:0]              lookup_addr,
    output logic                         hit,
    output logic [W_OPR-1:0]             hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR-1:0]  addr_q [DEPTH];
    logic [W_OPR-1:0] data_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    slot;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign head_idx  = addr_q[rd_ptr][IDX_W-1:0];
    assign head_data = data_q[rd_ptr];

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (addr_q[slot] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[slot];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: store buffer + single-port sync SRAM
//
// Purpose: accepts loads/stores from execute, buffers stores, drains them to SRAM when
//          the port is free, returns loads one cycle later with store-to-load forwarding.
// Ports:   clk; reset (sync, active-high); bus (slave side of dmem_responder_if).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int W_OPR    = W_OPR_DEF,
    parameter int ADDR     = ADDR_DEF,
    parameter int MEM_LOG2 = MEM_LOG2_DEF,
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_responder_if.slave       bus
);

    localparam int CW = $clog2(SB_DEPTH+1);

    logic [CW-1:0]       count;
    logic                full;
    logic [MEM_LOG2-1:0] head_idx;
    logic [W_OPR-1:0]    head_data;
    logic                hit;
    logic [W_OPR-1:0]    hit_data;
    port_grant_e         grant;
    logic                drain;
    logic                push;
    logic                serviced;
    logic                rejected;
    logic                dropped;

    logic [W_OPR-1:0]    mem [0:(1<<MEM_LOG2)-1];
    logic [W_OPR-1:0]    sram_q;
    logic                fwd_hit_q;
    logic [W_OPR-1:0]    fwd_data_q;
    logic                rd_valid_q;
    logic                err_q;

    assign full = (count == CW'(SB_DEPTH));

    // A raised ldst_read_i claims the port even when a simultaneous store makes the
    // load itself get rejected; this is what lets the buffer fill under load traffic.
    // Under hold the load slot is released so drains keep going.
    always_comb begin
        grant = GNT_IDLE;
        if (full)
            grant = GNT_DRAIN_FULL;
        else if (bus.ldst_read_i && !bus.hold_i)
            grant = GNT_LOAD;
        else if (count != '0)
            grant = GNT_DRAIN;
    end

    assign drain    = !reset && ((grant == GNT_DRAIN_FULL) || (grant == GNT_DRAIN));
    assign serviced = !reset && (grant == GNT_LOAD) && !bus.ldst_write_i;
    assign push     = !reset && bus.ldst_write_i && (!full || drain);
    // Cannot happen while a full buffer always drains; kept as a guard.
    assign dropped  = bus.ldst_write_i && full && !drain;
    assign rejected = bus.ldst_read_i && !bus.hold_i && (bus.ldst_write_i || (grant != GNT_LOAD));

    dmem_store_buffer #(
        .W_OPR (W_OPR),
        .ADDR  (ADDR),
        .DEPTH (SB_DEPTH),
        .IDX_W (MEM_LOG2)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (bus.ldst_addr_i),
        .push_data   (bus.ldst_data_i),
        .pop         (drain),
        .head_idx    (head_idx),
        .head_data   (head_data),
        .count       (count),
        .lookup_addr (bus.ldst_addr_i),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // SRAM array has no reset; its contents survive reset.
    always_ff @(posedge clk) begin
        if (drain) mem[head_idx] <= head_data;
    end

    // Read register, forward capture and status. Drain and serviced load are mutually
    // exclusive, so the array sees at most one access per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_q     <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (!bus.hold_i) begin
                rd_valid_q <= serviced;
                if (serviced) begin
                    sram_q     <= mem[bus.ldst_addr_i[MEM_LOG2-1:0]];
                    fwd_hit_q  <= hit;
                    fwd_data_q <= hit_data;
                end
            end
            if (rejected || dropped) err_q <= 1'b1;
        end
    end

    assign bus.ldst_data_o = fwd_hit_q ? fwd_data_q : sram_q;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.full_o      = full;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_responder_if bus ();

    dmem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [15:0] a, input logic [31:0] d);
        bus.ldst_write_i = wr;
        bus.ldst_read_i  = rd;
        bus.ldst_addr_i  = a;
        bus.ldst_data_i  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        bus.hold_i = 1'b0;
        drive(0, 0, 16'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        check("rst_data", bus.ldst_data_o, 32'h0);
        check("rst_rv", 32'(bus.rd_valid_o), 32'h0);
        check("rst_full", 32'(bus.full_o), 32'h0);
        check("rst_err", 32'(bus.err_o), 32'h0);

        // Store, let it drain, load it back from SRAM.
        drive(1, 0, 16'h0010, 32'h12345678); step();
        drive(0, 0, 16'h0, 32'h0); step(); step();
        drive(0, 1, 16'h0010, 32'h0); step();
        check("ld_sram_data", bus.ldst_data_o, 32'h12345678);
        check("ld_sram_rv", 32'(bus.rd_valid_o), 32'h1);
        drive(0, 0, 16'h0, 32'h0); step();
        check("rv_drop", 32'(bus.rd_valid_o), 32'h0);

        // Back-to-back stores to one address; SRAM holds 0xA, buffer holds 0xB.
        drive(1, 0, 16'h0020, 32'h0000000A); step();
        drive(1, 0, 16'h0020, 32'h0000000B); step();
        drive(0, 1, 16'h0020, 32'h0); step();
        check("fwd_data", bus.ldst_data_o, 32'h0000000B);
        check("fwd_rv", 32'(bus.rd_valid_o), 32'h1);
        check("err_clean", 32'(bus.err_o), 32'h0);
        drive(0, 0, 16'h0, 32'h0); step();

        // Hold freezes a load result while SRAM is rewritten underneath.
        drive(1, 0, 16'h0030, 32'h00000055); step();
        drive(0, 0, 16'h0, 32'h0); step();
        drive(0, 1, 16'h0030, 32'h0); step();
        check("hold_pre_data", bus.ldst_data_o, 32'h00000055);
        bus.hold_i = 1'b1;
        drive(1, 0, 16'h0030, 32'h00000099); step();
        check("hold1_data", bus.ldst_data_o, 32'h00000055);
        check("hold1_rv", 32'(bus.rd_valid_o), 32'h1);
        drive(0, 0, 16'h0, 32'h0); step();
        check("hold2_data", bus.ldst_data_o, 32'h00000055);
        check("hold2_rv", 32'(bus.rd_valid_o), 32'h1);
        drive(0, 1, 16'h0030, 32'h0); step();
        check("hold3_data", bus.ldst_data_o, 32'h00000055);
        check("hold3_rv", 32'(bus.rd_valid_o), 32'h1);
        bus.hold_i = 1'b0;
        drive(0, 0, 16'h0, 32'h0); step();
        check("post_hold_rv", 32'(bus.rd_valid_o), 32'h0);
        drive(0, 1, 16'h0030, 32'h0); step();
        check("rewrite_data", bus.ldst_data_o, 32'h00000099);

        // Loads with stores every cycle fill the buffer.
        drive(1, 1, 16'h0050, 32'h000000C1); step();
        check("rw_rv", 32'(bus.rd_valid_o), 32'h0);
        check("rw_err", 32'(bus.err_o), 32'h1);
        check("fill1_full", 32'(bus.full_o), 32'h0);
        drive(1, 1, 16'h0051, 32'h000000C2); step();
        drive(1, 1, 16'h0050, 32'h000000C3); step();
        check("fill3_full", 32'(bus.full_o), 32'h0);
        drive(1, 1, 16'h0050, 32'h000000C4); step();
        check("fill4_full", 32'(bus.full_o), 32'h1);
        drive(1, 1, 16'h0053, 32'h000000C5); step();
        check("full_push_full", 32'(bus.full_o), 32'h1);
        check("full_push_rv", 32'(bus.rd_valid_o), 32'h0);
        drive(0, 1, 16'h0051, 32'h0); step();
        check("lost_arb_rv", 32'(bus.rd_valid_o), 32'h0);
        check("lost_arb_err", 32'(bus.err_o), 32'h1);
        check("lost_arb_full", 32'(bus.full_o), 32'h0);
        drive(0, 1, 16'h0050, 32'h0); step();
        check("youngest_data", bus.ldst_data_o, 32'h000000C4);
        check("youngest_rv", 32'(bus.rd_valid_o), 32'h1);
        drive(0, 1, 16'h0450, 32'h0); step();
        check("alias_data", bus.ldst_data_o, 32'h000000C1);
        check("alias_rv", 32'(bus.rd_valid_o), 32'h1);
        drive(0, 0, 16'h0, 32'h0); step(); step(); step();
        check("err_sticky", 32'(bus.err_o), 32'h1);

        // Two buffered stores discarded by reset, which also beats a same-cycle store.
        drive(1, 1, 16'h0010, 32'h000000D1); step();
        drive(1, 1, 16'h0030, 32'h000000D2); step();
        check("pend_full", 32'(bus.full_o), 32'h0);
        reset = 1'b1;
        drive(1, 1, 16'h0010, 32'h000000EE); step();
        reset = 1'b0;
        drive(0, 0, 16'h0, 32'h0);
        check("rst2_data", bus.ldst_data_o, 32'h0);
        check("rst2_rv", 32'(bus.rd_valid_o), 32'h0);
        check("rst2_err", 32'(bus.err_o), 32'h0);
        check("rst2_full", 32'(bus.full_o), 32'h0);
        check("rst2_count", 32'(dut.count), 32'h0);
        step(); step();
        drive(0, 1, 16'h0010, 32'h0); step();
        check("rst2_ld10", bus.ldst_data_o, 32'h12345678);
        drive(0, 1, 16'h0030, 32'h0); step();
        check("rst2_ld30", bus.ldst_data_o, 32'h00000099);
        check("rst2_ld_rv", 32'(bus.rd_valid_o), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
